// File: rtl/mem_stage_pkg.sv
// Shared constants for the pipeline memory-access stage: aluop codes,
// big-endian byte-lane enables and the access FSM encoding.
package mem_stage_pkg;

    localparam int unsigned ALUOP_W = 8;
    localparam int unsigned SEL_W   = 4;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    // Big-endian: byte address 0 lives in bits [31:24]
    localparam logic [SEL_W-1:0] BYTE_SEL_NONE = 4'b0000;
    localparam logic [SEL_W-1:0] BYTE_SEL_B0   = 4'b1000;
    localparam logic [SEL_W-1:0] BYTE_SEL_H0   = 4'b1100;
    localparam logic [SEL_W-1:0] BYTE_SEL_H1   = 4'b0011;
    localparam logic [SEL_W-1:0] BYTE_SEL_W    = 4'b1111;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_BUSY = 2'b01,
        MEM_DONE = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_stage_lane.sv
// Combinational lane logic: byte enables, store-data replication,
// alignment check and load-data extraction/extension.
module mem_stage_lane
    import mem_stage_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic        is_mem_c,
    output logic        is_load_c,
    output logic [3:0]  sel_c,
    output logic [31:0] wdata_c,
    output logic        misalign_c,
    output logic [31:0] rdata_ext_c
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        is_mem_c    = 1'b0;
        is_load_c   = 1'b0;
        sel_c       = BYTE_SEL_NONE;
        wdata_c     = 32'h0;
        misalign_c  = 1'b0;
        rdata_ext_c = 32'h0;
        // Lane 0 is the most significant byte, hence the inverted offset
        byte_sh     = {~addr_lo, 3'b000};
        half_sh     = {~addr_lo[1], 4'b0000};
        byte_v      = rdata[byte_sh +: 8];
        half_v      = rdata[half_sh +: 16];

        case (aluop)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_mem_c    = 1'b1;
                is_load_c   = 1'b1;
                sel_c       = BYTE_SEL_B0 >> addr_lo;
                rdata_ext_c = (aluop == EXE_LB_OP) ? {{24{byte_v[7]}}, byte_v}
                                                   : {24'h0, byte_v};
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_mem_c    = 1'b1;
                is_load_c   = 1'b1;
                misalign_c  = addr_lo[0];
                sel_c       = addr_lo[1] ? BYTE_SEL_H1 : BYTE_SEL_H0;
                rdata_ext_c = (aluop == EXE_LH_OP) ? {{16{half_v[15]}}, half_v}
                                                   : {16'h0, half_v};
            end
            EXE_LW_OP: begin
                is_mem_c    = 1'b1;
                is_load_c   = 1'b1;
                misalign_c  = |addr_lo;
                sel_c       = BYTE_SEL_W;
                rdata_ext_c = rdata;
            end
            EXE_SB_OP: begin
                is_mem_c = 1'b1;
                sel_c    = BYTE_SEL_B0 >> addr_lo;
                wdata_c  = {4{reg2[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem_c   = 1'b1;
                misalign_c = addr_lo[0];
                sel_c      = addr_lo[1] ? BYTE_SEL_H1 : BYTE_SEL_H0;
                wdata_c    = {2{reg2[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem_c   = 1'b1;
                misalign_c = |addr_lo;
                sel_c      = BYTE_SEL_W;
                wdata_c    = reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: passes ALU results through and runs
// loads/stores over a registered req/ack bus, stalling until done.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [7:0]        mem_aluop,
    input  logic [ADDR_W-1:0] mem_mem_addr,
    input  logic [DATA_W-1:0] mem_reg2,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              stallreq,
    output logic              align_err,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic [DATA_W-1:0] dbus_rdata,
    input  logic              dbus_ack
);

    mem_state_e        state_q, state_d;
    logic              dbus_req_q, dbus_req_d;
    logic              dbus_we_q, dbus_we_d;
    logic [ADDR_W-1:0] dbus_addr_q, dbus_addr_d;
    logic [3:0]        dbus_sel_q, dbus_sel_d;
    logic [DATA_W-1:0] dbus_wdata_q, dbus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              is_mem, is_load, misalign;
    logic [3:0]        lane_sel;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;
    logic              unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    mem_stage_lane u_lane (
        .aluop       (mem_aluop),
        .addr_lo     (mem_mem_addr[1:0]),
        .reg2        (mem_reg2),
        .rdata       (dbus_rdata),
        .is_mem_c    (is_mem),
        .is_load_c   (is_load),
        .sel_c       (lane_sel),
        .wdata_c     (lane_wdata),
        .misalign_c  (misalign),
        .rdata_ext_c (lane_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MEM_IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_sel_q   <= 4'h0;
            dbus_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_sel_q   <= dbus_sel_d;
            dbus_wdata_q <= dbus_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_sel_d   = dbus_sel_q;
        dbus_wdata_d = dbus_wdata_q;
        rdata_d      = rdata_q;
        stallreq     = 1'b0;
        align_err    = 1'b0;
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;

        if (is_mem && misalign) begin
            align_err = 1'b1;
            wb_wd     = 5'd0;
            wb_wreg   = 1'b0;
            wb_wdata  = '0;
        end else if (is_mem) begin
            // No register write until the access has finished
            wb_wreg = 1'b0;
        end

        case (state_q)
            MEM_IDLE: begin
                if (is_mem && !misalign) begin
                    stallreq     = 1'b1;
                    state_d      = MEM_BUSY;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = ~is_load;
                    dbus_addr_d  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
                    dbus_sel_d   = lane_sel;
                    dbus_wdata_d = lane_wdata;
                end
            end
            MEM_BUSY: begin
                stallreq = 1'b1;
                if (dbus_ack) begin
                    rdata_d    = lane_rdata;
                    dbus_req_d = 1'b0;
                    state_d    = MEM_DONE;
                end
            end
            MEM_DONE: begin
                wb_wreg = is_load ? mem_wreg : 1'b0;
                if (is_load) begin
                    wb_wdata = rdata_q;
                end
                // Leave only once the op actually moves on to mem_wb
                if (!stall[4]) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_sel   = dbus_sel_q;
    assign dbus_wdata = dbus_wdata_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline. It sits between the ex_mem pipeline register and the mem_wb register.
- Forwards ALU results unchanged for non-memory ops.
- Runs loads and stores (byte, halfword, word) over a req/ack data bus, using a small FSM.
- Holds the pipeline through the stall controller (stallreq) until the access completes.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset (`RstEnable = 1'b1)
- stall  in  6  pipeline stall vector from the stall controller; stall[4] = mem stage held
- mem_wd  in  5  destination register from ex_mem
- mem_wreg  in  1  write enable from ex_mem
- mem_wdata  in  32  ALU result from ex_mem
- mem_aluop  in  8  operation code from ex_mem
- mem_mem_addr  in  32  effective address
- mem_reg2  in  32  store data
- wb_wd  out  5  to mem_wb
- wb_wreg  out  1  to mem_wb
- wb_wdata  out  32  to mem_wb
- stallreq  out  1  stall request to the stall controller
- align_err  out  1  misaligned access flag, valid in the cycle the op is presented
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = store, registered
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
- dbus_sel  out  4  byte lane enables, registered
- dbus_wdata  out  32  store data replicated into the lanes, registered
- dbus_rdata  in  32  read data, valid when dbus_ack = 1
- dbus_ack  in  1  access complete, one-cycle pulse

Behaviour:
- Memory op = mem_aluop in {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP}. Every other op, including EXE_NOP_OP, passes through combinationally: wb_* = mem_*, stallreq = 0.
- Byte order is big-endian.
  - addr[1:0]=00 → sel 1000, byte in bits [31:24]; 01 → 0100; 10 → 0010; 11 → 0001.
  - Halfword: addr[1]=0 → sel 1100; addr[1]=1 → sel 0011.
  - Word: sel 1111.
- Store data replication: SB → {4{reg2[7:0]}}; SH → {2{reg2[15:0]}}; SW → reg2.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend the selected lane; LW takes the full word.
- Misalignment:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is misaligned.
  - A misaligned op issues no bus access and raises align_err=1 combinationally.
  - It forces wb_wreg=0, wb_wd=0, wb_wdata=0 and leaves stallreq=0.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
  - IDLE, aligned memory op present:
    - stallreq=1 combinationally.
    - Next edge: load dbus_req=1 and dbus_we/addr/sel/wdata, go to BUSY.
  - BUSY:
    - stallreq=1; bus outputs are held stable.
    - On an edge with dbus_ack=1: capture the lane-extended dbus_rdata into the internal rdata_q, clear dbus_req, go to DONE.
    - dbus_ack in IDLE or DONE is ignored.
  - DONE:
    - stallreq=0.
    - Load: wb_wdata=rdata_q, wb_wd/wb_wreg = inputs. Store: wb_wreg=0.
    - Go to IDLE on the first edge with stall[4]=0, i.e. when the op leaves the stage. If stall[4]=1 (downstream stall), remain in DONE and do not reissue.
- Timing: minimum 2 stall cycles per access (request cycle plus ack cycle). Throughput is one memory op per 3 cycles when ack returns immediately.
- Reset: rst=1 forces IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, rdata_q=0 immediately, without waiting for a clock edge.
  - Reset mid-BUSY abandons the transaction. An ack that arrives later is ignored.
  - The combinational outputs follow their inputs; ex_mem is itself reset to NOP, so wb_* = 0 and stallreq = 0.
- Store-to-load ordering is handled by serial issue only; there is no store buffer.

Decomposition:
- defines.v gets new entries: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP aluop codes, ByteSel* lane constants, and the FSM state encodings (MemIdle, MemBusy, MemDone, 2 bits).
- One combinational sub-module, mem_lane. It computes sel, the replicated write data, the misalign flag and the extended load data from aluop, addr[1:0], reg2 and rdata.
- mem_stage contains the FSM, the bus registers and rdata_q.

Test Plan:
1. ALU passthrough: aluop=EXE_OR_OP, wd=5, wreg=1, wdata=0x1234 → wb_*=(5,1,0x1234) same cycle; stallreq=0; dbus_req never rises.
2. Signed byte load: LB at addr 0x103, ack on the first BUSY cycle with rdata=0x000000F0.
   - Required: dbus_sel=0001 and dbus_addr=0x100.
   - Required: exactly 2 stallreq cycles, then wb_wdata=0xFFFFFFF0.
   - Repeat with LBU: wb_wdata=0x000000F0.
3. Halfword store with slow ack: SH at addr 0x202, reg2=0xAABBCCDD, ack after 4 cycles.
   - Required: dbus_we=1, sel=0011, wdata=0xCCDDCCDD, all held stable for 4 cycles.
   - Required: stallreq=1 for 5 cycles, then wb_wreg=0.
4. Misaligned word: LW at addr 0x301 → align_err=1, dbus_req=0, stallreq=0, wb_wreg=0.
5. Downstream stall in DONE: LW completes with rdata=0xDEADBEEF while stall[4]=1 for 3 cycles.
   - Required: wb_wdata holds 0xDEADBEEF and no second request is issued.
   - Required: FSM returns to IDLE after stall[4] falls.
6. Reset in BUSY: assert rst while dbus_req=1.
   - Required: dbus_req=0 before the next clock edge.
   - Required: a later dbus_ack is ignored and the next op is issued normally.
